// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Brief    : In-order commit buffer with dual writeback ports, a registered
//             CDB/register-write broadcast and branch-mispredict flush.
//  Revision : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rd,
    input  logic        alloc_branch,
    input  logic        alloc_pred_taken,
    input  logic [31:0] alloc_alt_addr,
    output logic [3:0]  alloc_tag,
    output logic        rob_full,

    input  logic        rs_submit_valid,
    input  logic [3:0]  rs_submit_tag,
    input  logic [31:0] rs_submit_val,

    input  logic        lsb_submit_valid,
    input  logic [3:0]  lsb_submit_tag,
    input  logic [31:0] lsb_submit_val,

    output logic        cdb_active,
    output logic [3:0]  cdb_tag,
    output logic [31:0] cdb_val,

    output logic [4:0]  commit_rd,
    output logic [31:0] commit_val,

    output logic        flush,
    output logic [31:0] flush_addr
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    typedef logic [c_ptr_w-1:0] ptr_t;
    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam ptr_t c_last_ptr  = ptr_t'(DEPTH - 1);
    localparam cnt_t c_depth_cnt = cnt_t'(DEPTH);

    ptr_t             r_head;
    ptr_t             r_tail;
    cnt_t             r_count;
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_branch;
    logic [DEPTH-1:0] r_pred;
    logic [4:0]       r_rd  [DEPTH];
    logic [31:0]      r_val [DEPTH];
    logic [31:0]      r_alt [DEPTH];

    logic [DEPTH-1:0] w_rs_hit;
    logic [DEPTH-1:0] w_lsb_hit;
    logic [DEPTH-1:0] w_alloc_hit;
    logic [DEPTH-1:0] w_commit_hit;
    logic             w_alloc_fire;
    logic             w_commit;
    logic             w_head_taken;
    logic             w_mispredict;
    logic             w_retire_reg;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == c_last_ptr) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic logic [3:0] tag_of(input ptr_t p);
        return 4'(p) + 4'd1;
    endfunction

    assign rob_full  = (r_count == c_depth_cnt);
    assign alloc_tag = rob_full ? 4'd0 : tag_of(r_tail);

    assign w_alloc_fire = alloc_valid & ~rob_full;
    // Head eligibility uses only registered ready, so a same-edge writeback waits a cycle.
    assign w_commit     = r_busy[r_head] & r_ready[r_head];
    assign w_head_taken = r_val[r_head][0];
    assign w_mispredict = w_commit & r_branch[r_head] & (w_head_taken != r_pred[r_head]);
    assign w_retire_reg = w_commit & ~r_branch[r_head];

    // Tag 0 and tags beyond DEPTH never match any entry, so they fall out naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign w_rs_hit[i]     = rs_submit_valid  & (rs_submit_tag  == 4'(i + 1)) & r_busy[i];
        assign w_lsb_hit[i]    = lsb_submit_valid & (lsb_submit_tag == 4'(i + 1)) & r_busy[i];
        assign w_alloc_hit[i]  = w_alloc_fire & (r_tail == ptr_t'(i));
        assign w_commit_hit[i] = w_commit & (r_head == ptr_t'(i));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_busy     <= '0;
            r_ready    <= '0;
            r_branch   <= '0;
            r_pred     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= '0;
                r_val[i] <= '0;
                r_alt[i] <= '0;
            end
            cdb_active <= 1'b0;
            cdb_tag    <= '0;
            cdb_val    <= '0;
            commit_rd  <= '0;
            commit_val <= '0;
            flush      <= 1'b0;
            flush_addr <= '0;
        end else if (rdy_in) begin
            cdb_active <= 1'b0;
            flush      <= 1'b0;
            commit_rd  <= '0;

            if (w_mispredict) begin
                // Everything younger than the branch is wrong-path: drop it all.
                flush      <= 1'b1;
                flush_addr <= r_alt[r_head];
                r_busy     <= '0;
                r_ready    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else begin
                if (w_retire_reg) begin
                    cdb_active <= 1'b1;
                    cdb_tag    <= tag_of(r_head);
                    cdb_val    <= r_val[r_head];
                    commit_rd  <= r_rd[r_head];
                    commit_val <= r_val[r_head];
                end

                if (w_commit)
                    r_head <= ptr_next(r_head);
                if (w_alloc_fire)
                    r_tail <= ptr_next(r_tail);

                case ({w_alloc_fire, w_commit})
                    2'b10:   r_count <= r_count + cnt_t'(1);
                    2'b01:   r_count <= r_count - cnt_t'(1);
                    default: r_count <= r_count;
                endcase

                for (int i = 0; i < DEPTH; i++) begin
                    if (w_commit_hit[i]) begin
                        r_busy[i]  <= 1'b0;
                        r_ready[i] <= 1'b0;
                    end else if (w_alloc_hit[i]) begin
                        r_busy[i]   <= 1'b1;
                        r_ready[i]  <= 1'b0;
                        r_rd[i]     <= alloc_rd;
                        r_branch[i] <= alloc_branch;
                        r_pred[i]   <= alloc_pred_taken;
                        r_alt[i]    <= alloc_alt_addr;
                    end else if (w_rs_hit[i]) begin
                        r_val[i]   <= rs_submit_val;
                        r_ready[i] <= 1'b1;
                    end else if (w_lsb_hit[i]) begin
                        r_val[i]   <= lsb_submit_val;
                        r_ready[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Brief    : Directed scoreboard bench for reorder_buffer commit/flush order.
//  Revision : 1.0
// ============================================================================
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        alloc_valid, alloc_branch, alloc_pred_taken;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_alt_addr;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        rs_submit_valid, lsb_submit_valid;
    logic [3:0]  rs_submit_tag, lsb_submit_tag;
    logic [31:0] rs_submit_val, lsb_submit_val;
    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        flush;
    logic [31:0] flush_addr;

    typedef struct {
        bit          is_flush;
        logic [3:0]  tag;
        logic [31:0] val;
        logic [4:0]  rd;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    reorder_buffer #(.DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_branch(alloc_branch),
        .alloc_pred_taken(alloc_pred_taken), .alloc_alt_addr(alloc_alt_addr),
        .alloc_tag(alloc_tag), .rob_full(rob_full),
        .rs_submit_valid(rs_submit_valid), .rs_submit_tag(rs_submit_tag),
        .rs_submit_val(rs_submit_val),
        .lsb_submit_valid(lsb_submit_valid), .lsb_submit_tag(lsb_submit_tag),
        .lsb_submit_val(lsb_submit_val),
        .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .commit_rd(commit_rd), .commit_val(commit_val),
        .flush(flush), .flush_addr(flush_addr)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_cdb(input logic [3:0] tag, input logic [31:0] val, input logic [4:0] rd);
        exp_t e;
        e.is_flush = 1'b0; e.tag = tag; e.val = val; e.rd = rd; e.addr = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_flush(input logic [31:0] addr);
        exp_t e;
        e.is_flush = 1'b1; e.tag = '0; e.val = '0; e.rd = '0; e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic clear_submits();
        rs_submit_valid = 1'b0; rs_submit_tag = '0; rs_submit_val = '0;
        lsb_submit_valid = 1'b0; lsb_submit_tag = '0; lsb_submit_val = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pred, input logic [31:0] alt);
        alloc_valid = 1'b1; alloc_rd = rd; alloc_branch = br;
        alloc_pred_taken = pred; alloc_alt_addr = alt;
        tick();
        alloc_valid = 1'b0; alloc_branch = 1'b0; alloc_pred_taken = 1'b0;
    endtask

    // Pops one expectation per enabled edge on which the DUT pulses a commit or flush.
    task automatic monitor_loop();
        exp_t e;
        logic lr, lrst;
        forever begin
            @(posedge clk_in);
            lr   = rdy_in;
            lrst = rst_in;
            @(negedge clk_in);
            if (lr && !lrst && (cdb_active || flush)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event cdb_active=%0d tag=%0d flush=%0d expected=none at %0t",
                             cdb_active, cdb_tag, flush, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_flush) begin
                        check("flush_seen", 32'(flush), 32'd1);
                        check("flush_addr", flush_addr, e.addr);
                        check("flush_no_cdb", 32'(cdb_active), 32'd0);
                        check("flush_no_rd", 32'(commit_rd), 32'd0);
                    end else begin
                        check("cdb_active", 32'(cdb_active), 32'd1);
                        check("cdb_tag", 32'(cdb_tag), 32'(e.tag));
                        check("cdb_val", cdb_val, e.val);
                        check("commit_rd", 32'(commit_rd), 32'(e.rd));
                        check("commit_val", commit_val, e.val);
                        check("cdb_no_flush", 32'(flush), 32'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_branch = 1'b0;
        alloc_pred_taken = 1'b0; alloc_alt_addr = '0;
        clear_submits();
        fork
            monitor_loop();
        join_none

        // Reset state
        do_reset();
        check("rst_alloc_tag", 32'(alloc_tag), 32'd1);
        check("rst_rob_full", 32'(rob_full), 32'd0);
        check("rst_cdb_active", 32'(cdb_active), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_commit_rd", 32'(commit_rd), 32'd0);
        check("rst_flush_addr", flush_addr, 32'd0);

        // Single allocate / writeback / commit
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        check("first_alloc_tag", 32'(alloc_tag), 32'd1);
        tick();
        alloc_valid = 1'b0;
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h2A;
        push_cdb(4'd1, 32'h2A, 5'd5);
        tick();
        clear_submits();
        tick();
        tick();

        // Fill, refuse while full (also on the commit edge), then reuse tag 1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
            check("fill_alloc_tag", 32'(alloc_tag), 32'(i + 1));
            tick();
        end
        check("full_rob_full", 32'(rob_full), 32'd1);
        check("full_alloc_tag", 32'(alloc_tag), 32'd0);
        alloc_rd = 5'd31;
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h55;
        push_cdb(4'd1, 32'h55, 5'd1);
        tick();
        clear_submits();
        check("ninth_refused", 32'(rob_full), 32'd1);
        tick();
        check("wrap_rob_full", 32'(rob_full), 32'd0);
        check("wrap_alloc_tag", 32'(alloc_tag), 32'd1);
        alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0;
        check("refill_rob_full", 32'(rob_full), 32'd1);
        check("refill_alloc_tag", 32'(alloc_tag), 32'd0);

        // Out-of-order writeback, in-order commit
        do_reset();
        check("midop_reset_tag", 32'(alloc_tag), 32'd1);
        check("midop_reset_full", 32'(rob_full), 32'd0);
        alloc(5'd10, 1'b0, 1'b0, 32'h0);
        alloc(5'd11, 1'b0, 1'b0, 32'h0);
        lsb_submit_valid = 1'b1; lsb_submit_tag = 4'd2; lsb_submit_val = 32'h222;
        tick();
        clear_submits();
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h111;
        push_cdb(4'd1, 32'h111, 5'd10);
        push_cdb(4'd2, 32'h222, 5'd11);
        tick();
        clear_submits();
        tick();
        tick();
        tick();

        // Dual-port writeback and same-tag priority
        do_reset();
        alloc(5'd1, 1'b0, 1'b0, 32'h0);
        alloc(5'd2, 1'b0, 1'b0, 32'h0);
        alloc(5'd3, 1'b0, 1'b0, 32'h0);
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h1;
        lsb_submit_valid = 1'b1; lsb_submit_tag = 4'd2; lsb_submit_val = 32'h2;
        push_cdb(4'd1, 32'h1, 5'd1);
        push_cdb(4'd2, 32'h2, 5'd2);
        push_cdb(4'd3, 32'h11, 5'd3);
        tick();
        rs_submit_tag = 4'd3; rs_submit_val = 32'h11;
        lsb_submit_tag = 4'd3; lsb_submit_val = 32'h22;
        tick();
        clear_submits();
        for (int i = 0; i < 4; i++) tick();

        // Correctly predicted branch retires silently
        do_reset();
        alloc(5'd0, 1'b1, 1'b1, 32'hDEAD);
        alloc(5'd4, 1'b0, 1'b0, 32'h0);
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h1;
        lsb_submit_valid = 1'b1; lsb_submit_tag = 4'd2; lsb_submit_val = 32'h99;
        push_cdb(4'd2, 32'h99, 5'd4);
        tick();
        clear_submits();
        for (int i = 0; i < 4; i++) tick();

        // Mispredicted branch flushes younger entries
        do_reset();
        alloc(5'd0, 1'b1, 1'b0, 32'h1000);
        alloc(5'd2, 1'b0, 1'b0, 32'h0);
        alloc(5'd3, 1'b0, 1'b0, 32'h0);
        lsb_submit_valid = 1'b1; lsb_submit_tag = 4'd2; lsb_submit_val = 32'h77;
        tick();
        clear_submits();
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h1;
        push_flush(32'h1000);
        tick();
        clear_submits();
        tick();
        check("flush_pulse", 32'(flush), 32'd1);
        check("post_flush_tag", 32'(alloc_tag), 32'd1);
        check("post_flush_full", 32'(rob_full), 32'd0);
        tick();
        check("flush_one_cycle", 32'(flush), 32'd0);
        alloc_valid = 1'b1; alloc_rd = 5'd6;
        check("realloc_tag", 32'(alloc_tag), 32'd1);
        tick();
        alloc_valid = 1'b0;
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h33;
        push_cdb(4'd1, 32'h33, 5'd6);
        tick();
        clear_submits();
        for (int i = 0; i < 3; i++) tick();

        // Stall with rdy_in low: outputs frozen, commit waits
        do_reset();
        alloc(5'd7, 1'b0, 1'b0, 32'h0);
        alloc(5'd8, 1'b0, 1'b0, 32'h0);
        rs_submit_valid = 1'b1; rs_submit_tag = 4'd1; rs_submit_val = 32'h44;
        lsb_submit_valid = 1'b1; lsb_submit_tag = 4'd2; lsb_submit_val = 32'h45;
        push_cdb(4'd1, 32'h44, 5'd7);
        push_cdb(4'd2, 32'h45, 5'd8);
        tick();
        clear_submits();
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_cdb_active", 32'(cdb_active), 32'd1);
            check("stall_cdb_tag", 32'(cdb_tag), 32'd1);
            check("stall_cdb_val", cdb_val, 32'h44);
            check("stall_commit_rd", 32'(commit_rd), 32'd7);
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; tags are 4 bits, tag = entry index + 1, 4'b0000 = no tag.
REQ-002 SHALL have ports clk_in in 1, clock; rst_in in 1, synchronous active-high reset; rdy_in in 1, global enable.
REQ-003 SHALL have alloc_valid in 1, allocation request from issue.
REQ-004 SHALL have alloc_rd in 5, destination register; alloc_branch in 1, entry is a conditional branch.
REQ-005 SHALL have alloc_pred_taken in 1, predicted direction; alloc_alt_addr in 32, redirect PC if mispredicted.
REQ-006 SHALL have alloc_tag out 4, tag granted to the current request; rob_full out 1, no free entry.
REQ-007 SHALL have rs_submit_valid in 1, rs_submit_tag in 4, rs_submit_val in 32, ALU writeback port.
REQ-008 SHALL have lsb_submit_valid in 1, lsb_submit_tag in 4, lsb_submit_val in 32, load/store writeback port.
REQ-009 SHALL have cdb_active out 1, cdb_tag out 4, cdb_val out 32, commit broadcast.
REQ-010 SHALL have commit_rd out 5, commit_val out 32, register write (commit_rd = 0 means no write).
REQ-011 SHALL have flush out 1, flush_addr out 32, mispredict redirect.

Function
REQ-012 SHALL hold entries in a circular buffer with head/tail pointers that wrap DEPTH-1 -> 0 and a count of 0..DEPTH.
REQ-013 SHALL drive rob_full = (count == DEPTH) and alloc_tag = rob_full ? 0 : tail+1, both combinational from registered state.
REQ-014 SHALL, on an edge with rdy_in & alloc_valid & !rob_full, write the tail entry as busy, not ready, with the alloc fields; then advance tail.
REQ-015 SHALL refuse allocation while full even if a commit occurs on the same edge.
REQ-016 SHALL, on each submit port with valid & tag != 0 & entry busy, store the value and set ready; a submit to a non-busy entry or tag 0 is ignored.
REQ-017 SHALL accept both submit ports on one edge; if both name the same tag, the rs port wins.
REQ-018 SHALL commit at most one entry per edge: the head, only if busy and ready at the start of the cycle (no same-edge writeback bypass).
REQ-019 SHALL, on commit of a non-branch entry, register next cycle: cdb_active=1, cdb_tag=head tag, cdb_val=value, commit_rd=rd, commit_val=value; clear the entry, advance head.
REQ-020 SHALL treat a branch entry's value bit 0 as actual taken; on commit with taken == pred_taken, clear the entry without CDB or register write.
REQ-021 SHALL, on commit of a branch with taken != pred_taken, register flush=1, flush_addr=alt_addr for one cycle, clear all entries, set head=tail=0, count=0, and drop any same-edge allocation and writeback.
REQ-022 SHALL deassert cdb_active, flush, and set commit_rd=0 on every enabled edge with no corresponding event (single-cycle pulses).
REQ-023 SHALL update count by +1 alloc, -1 commit, net 0 when both occur on one edge.
REQ-024 SHALL, while rdy_in=0, hold all state and all registered outputs unchanged.

Reset
REQ-025 SHALL, on an edge with rst_in=1 (priority over rdy_in), clear all entries, pointers and count; set cdb_active=0, cdb_tag=0, cdb_val=0, commit_rd=0, commit_val=0, flush=0, flush_addr=0.
REQ-026 SHALL abandon all in-flight entries on reset mid-operation; after reset, alloc_tag=1 and rob_full=0.

Verification
REQ-027 Reset then alloc rd=5 -> alloc_tag=1; rs_submit tag1 val=0x2A; next edge commit -> following cycle cdb_active=1, cdb_tag=1, cdb_val=0x2A, commit_rd=5.
REQ-028 Allocate 8 with no submits -> rob_full=1, alloc_tag=0; ninth alloc_valid leaves count at 8; submit tag1 plus commit -> tag1 reused after wrap.
REQ-029 Allocate tags 1,2; submit tag2 first, then tag1 -> commits strictly tag1 then tag2 on consecutive cycles.
REQ-030 Same-edge rs and lsb submits to tag3 with vals 0x11 and 0x22 -> tag3 commits 0x11.
REQ-031 Branch tag1 pred_taken=0, alt_addr=0x1000, tags 2-3 allocated; submit tag1 val=1 -> flush=1, flush_addr=0x1000 one cycle; next alloc_tag=1, count=0.
REQ-032 Hold rdy_in=0 across a ready head for 3 cycles -> no commit, outputs frozen; commit occurs on first edge with rdy_in=1.
